countone_hls_deadlock_monitor_gen: RTL and testbench
====================================================

COUNTONE_HLS_DEADLOCK_MONITOR_GEN -- requirements
Module: countone_hls_deadlock_monitor_gen

Interface
REQ-001 SHALL have parameter NUM_AXIS, default 3: number of AXI-stream block inputs.
REQ-002 SHALL have parameter AXIS_MASK, default 3'b110: per-channel enable; only set bits participate.
REQ-003 SHALL have parameter NUM_INST, default 2: number of sub-instance idle/block pairs.
REQ-004 SHALL have parameter PERSIST, default 1, range 1..255: consecutive cycles a block condition must hold before reporting.
REQ-005 SHALL have parameter CNT_W, default 16: width of block_cycles.
REQ-006 SHALL have derived localparam CH_W = clog2(NUM_AXIS+1).
REQ-007 SHALL have port clock, input, 1: the only clock; all logic on posedge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port axis_block_sigs, input, NUM_AXIS: per-channel stream-blocked flags.
REQ-010 SHALL have port inst_idle_sigs, input, NUM_INST: sub-instance idle flags.
REQ-011 SHALL have port inst_block_sigs, input, NUM_INST: sub-instance block flags.
REQ-012 SHALL have port clear, input, 1: single-cycle request to drop the report.
REQ-013 SHALL have port block, output, 1: deadlock reported.
REQ-014 SHALL have port block_ch, output, CH_W: first blocking channel index; NUM_AXIS means sub-instance cause.
REQ-015 SHALL have port block_cycles, output, CNT_W: cycles spent in BLOCKED, saturating.

Function
REQ-016 SHALL compute raw = |(axis_block_sigs & AXIS_MASK) | |(inst_block_sigs & ~inst_idle_sigs), combinationally.
REQ-017 SHALL implement FSM states IDLE, PEND, BLOCKED; block = 1 exactly in BLOCKED (registered).
REQ-018 In IDLE with raw=1: if PERSIST=1 go BLOCKED, else go PEND with persist count = 1.
REQ-019 In PEND: raw=1 increments persist count; on the edge where it would reach PERSIST go BLOCKED; raw=0 returns to IDLE, count = 0.
REQ-020 With PERSIST=1, block SHALL rise one cycle after raw rises and fall one cycle after raw falls (non-sticky build).
REQ-021 On entry to BLOCKED, block_ch SHALL capture the lowest set index of axis_block_sigs & AXIS_MASK, or NUM_AXIS if that vector is zero; held constant while in BLOCKED.
REQ-022 block_cycles SHALL load 1 on entry to BLOCKED, increment each further BLOCKED cycle, saturate at all-ones, and hold its last value after leaving BLOCKED until next entry.
REQ-023 In BLOCKED with raw=0 (non-sticky build) SHALL return to IDLE next edge.
REQ-024 clear=1 SHALL force IDLE and zero persist count from any state; clear has priority over raw in the same cycle; raw is re-evaluated from the next cycle.
REQ-025 Input bits with AXIS_MASK=0 SHALL have no effect on any output.

Reset
REQ-026 reset=1 at a posedge SHALL set state IDLE, persist count 0, block 0, block_ch 0, block_cycles 0, overriding clear and raw.
REQ-027 Reset asserted mid-PEND or mid-BLOCKED SHALL discard progress; counting restarts from zero after release.

Configuration
REQ-028 Macro COUNTONE_DEADLOCK_STICKY_EN: when defined, BLOCKED SHALL be left only by clear or reset, regardless of raw; block_cycles keeps counting while held.
REQ-029 When undefined, REQ-023 applies and clear still works per REQ-024.

Verification
REQ-030 Defaults, axis_block_sigs=3'b010 for 1 cycle -> block=1 for exactly the next cycle, block_ch=1, block_cycles=1.
REQ-031 Defaults, axis_block_sigs=3'b001 held 10 cycles -> block stays 0 (masked).
REQ-032 PERSIST=4, raw high 3 cycles, low 1, high 4 -> block rises only on edge after 4th consecutive high cycle.
REQ-033 inst_block_sigs=2'b01, inst_idle_sigs=2'b00 -> block=1, block_ch=3; same with inst_idle_sigs=2'b01 -> block=0.
REQ-034 Sticky build: raw high 5 cycles then low -> block stays 1, block_cycles increments; clear pulse -> block=0 next cycle.
REQ-035 CNT_W=4, raw held 20 cycles -> block_cycles saturates at 15; reset during BLOCKED -> all outputs 0 next cycle.

Source files
------------

// File: rtl/countone_hls_deadlock_monitor_gen.sv
// Purpose : flags a stalled HLS dataflow region from stream-blocked and sub-instance block/idle flags.
// Latency : block follows the qualified block condition by PERSIST cycles (one cycle when PERSIST=1).
// Backpres: pure observer; it never stalls anything and accepts its inputs every cycle.
//
// Ports
//   clock           - the only clock, all state on its rising edge
//   reset           - synchronous, active-high; returns everything to zero/IDLE
//   axis_block_sigs - per-channel stream-blocked flags (only AXIS_MASK bits count)
//   inst_idle_sigs  - sub-instance idle flags
//   inst_block_sigs - sub-instance block flags (ignored while that instance is idle)
//   clear           - one-cycle request to drop the report and restart qualification
//   block           - deadlock reported (high exactly while in BLOCKED)
//   block_ch        - lowest blocking channel captured on entry; NUM_AXIS = sub-instance cause
//   block_cycles    - cycles spent in BLOCKED, saturating, held after exit
//
// Build option: define COUNTONE_DEADLOCK_STICKY_EN to make BLOCKED leave only on clear/reset.

module countone_hls_deadlock_monitor_gen #(
   parameter int unsigned          NUM_AXIS  = 3,
   parameter logic [NUM_AXIS-1:0]  AXIS_MASK = 3'b110,
   parameter int unsigned          NUM_INST  = 2,
   parameter int unsigned          PERSIST   = 1,
   parameter int unsigned          CNT_W     = 16,
   localparam int unsigned         CH_W      = $clog2(NUM_AXIS + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_AXIS-1:0] axis_block_sigs,
   input  logic [NUM_INST-1:0] inst_idle_sigs,
   input  logic [NUM_INST-1:0] inst_block_sigs,
   input  logic                clear,
   output logic                block,
   output logic [CH_W-1:0]     block_ch,
   output logic [CNT_W-1:0]    block_cycles
);

   // PERSIST is limited to 1..255, so an 8-bit qualification counter is enough.
   localparam logic [7:0] PERSIST_V = 8'(PERSIST);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PEND    = 2'd1,
      ST_BLOCKED = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [7:0]          persist_cnt_q, persist_cnt_d;
   logic [CH_W-1:0]     block_ch_q, block_ch_d;
   logic [CNT_W-1:0]    block_cycles_q, block_cycles_d;

   logic [NUM_AXIS-1:0] axis_masked;
   logic                raw;
   logic [CH_W-1:0]     first_ch;
   logic                enter_blocked;

   // ------------------------------------------------------------------
   // Block condition. A sub-instance that reports idle cannot be the
   // cause of a stall, so its block flag is discarded.
   // ------------------------------------------------------------------
   assign axis_masked = axis_block_sigs & AXIS_MASK;
   assign raw         = (|axis_masked) | (|(inst_block_sigs & ~inst_idle_sigs));

   // Lowest set masked channel; falls back to NUM_AXIS when only a
   // sub-instance is responsible. Scanning downward lets the lowest win.
   always_comb begin
      first_ch = CH_W'(NUM_AXIS);
      for (int i = int'(NUM_AXIS) - 1; i >= 0; i--) begin
         if (axis_masked[i]) begin
            first_ch = CH_W'(i);
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM process 1: state and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         persist_cnt_q  <= '0;
         block_ch_q     <= '0;
         block_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         persist_cnt_q  <= persist_cnt_d;
         block_ch_q     <= block_ch_d;
         block_cycles_q <= block_cycles_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM process 2: next state and qualification counter.
   // clear wins over raw; raw is looked at again from the following cycle.
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      persist_cnt_d = persist_cnt_q;
      enter_blocked = 1'b0;

      if (clear) begin
         state_d       = ST_IDLE;
         persist_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (raw) begin
                  if (PERSIST_V == 8'd1) begin
                     state_d       = ST_BLOCKED;
                     enter_blocked = 1'b1;
                  end else begin
                     state_d       = ST_PEND;
                     persist_cnt_d = 8'd1;
                  end
               end
            end

            ST_PEND: begin
               if (!raw) begin
                  state_d       = ST_IDLE;
                  persist_cnt_d = '0;
               end else if (persist_cnt_q + 8'd1 == PERSIST_V) begin
                  // The count would reach PERSIST on this edge: report now.
                  state_d       = ST_BLOCKED;
                  persist_cnt_d = '0;
                  enter_blocked = 1'b1;
               end else begin
                  persist_cnt_d = persist_cnt_q + 8'd1;
               end
            end

            ST_BLOCKED: begin
`ifdef COUNTONE_DEADLOCK_STICKY_EN
               // Held until clear or reset regardless of raw.
               state_d = ST_BLOCKED;
`else
               if (!raw) begin
                  state_d = ST_IDLE;
               end
`endif
            end

            default: begin
               state_d       = ST_IDLE;
               persist_cnt_d = '0;
            end
         endcase
      end
   end

   // Cause capture and dwell counter. The counter is only written on entry
   // or while staying in BLOCKED, so it keeps its last value after exit.
   always_comb begin
      block_ch_d     = block_ch_q;
      block_cycles_d = block_cycles_q;

      if (enter_blocked) begin
         block_ch_d     = first_ch;
         block_cycles_d = CNT_W'(1);
      end else if ((state_q == ST_BLOCKED) && (state_d == ST_BLOCKED) &&
                   (block_cycles_q != {CNT_W{1'b1}})) begin
         block_cycles_d = block_cycles_q + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // FSM process 3: outputs, all decoded from registers
   // ------------------------------------------------------------------
   always_comb begin
      block        = (state_q == ST_BLOCKED);
      block_ch     = block_ch_q;
      block_cycles = block_cycles_q;
   end

endmodule

// File: tb/tb_countone_hls_deadlock_monitor_gen.sv
// Purpose : directed checks of the deadlock monitor in three parameterisations.
// Latency : each stimulus is applied, one clock edge taken, outputs sampled 1 time unit later.
// Backpres: not applicable; fixed-length directed sequence, always terminates.

module tb_countone_hls_deadlock_monitor_gen;

`ifdef COUNTONE_DEADLOCK_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] axis_sigs = '0;
   logic [1:0] inst_idle = '0;
   logic [1:0] inst_blk  = '0;
   logic       clear = 1'b0;

   // default build
   logic        d0_blk;
   logic [1:0]  d0_ch;
   logic [15:0] d0_cyc;
   // PERSIST = 4
   logic        p4_blk;
   logic [1:0]  p4_ch;
   logic [15:0] p4_cyc;
   // CNT_W = 4
   logic        c4_blk;
   logic [1:0]  c4_ch;
   logic [3:0]  c4_cyc;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   countone_hls_deadlock_monitor_gen u_d0 (
      .clock(clock), .reset(reset), .axis_block_sigs(axis_sigs),
      .inst_idle_sigs(inst_idle), .inst_block_sigs(inst_blk), .clear(clear),
      .block(d0_blk), .block_ch(d0_ch), .block_cycles(d0_cyc));

   countone_hls_deadlock_monitor_gen #(.PERSIST(4)) u_p4 (
      .clock(clock), .reset(reset), .axis_block_sigs(axis_sigs),
      .inst_idle_sigs(inst_idle), .inst_block_sigs(inst_blk), .clear(clear),
      .block(p4_blk), .block_ch(p4_ch), .block_cycles(p4_cyc));

   countone_hls_deadlock_monitor_gen #(.CNT_W(4)) u_c4 (
      .clock(clock), .reset(reset), .axis_block_sigs(axis_sigs),
      .inst_idle_sigs(inst_idle), .inst_block_sigs(inst_blk), .clear(clear),
      .block(c4_blk), .block_ch(c4_ch), .block_cycles(c4_cyc));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      axis_sigs = '0;
      inst_idle = '0;
      inst_blk  = '0;
      clear     = 1'b0;
      tick();
      reset     = 1'b0;
   endtask

   initial begin
      // ---------------- reset state
      do_reset();
      check_val("rst_d0_blk", 32'(d0_blk), 32'd0);
      check_val("rst_d0_ch",  32'(d0_ch),  32'd0);
      check_val("rst_d0_cyc", 32'(d0_cyc), 32'd0);
      check_val("rst_p4_blk", 32'(p4_blk), 32'd0);
      check_val("rst_c4_cyc", 32'(c4_cyc), 32'd0);

      // ---------------- single-cycle block on channel 1
      axis_sigs = 3'b010;
      tick();
      check_val("pulse_blk", 32'(d0_blk), 32'd1);
      check_val("pulse_ch",  32'(d0_ch),  32'd1);
      check_val("pulse_cyc", 32'(d0_cyc), 32'd1);
      axis_sigs = 3'b000;
      tick();
      check_val("pulse_fall_blk", 32'(d0_blk), STICKY ? 32'd1 : 32'd0);
      check_val("pulse_fall_cyc", 32'(d0_cyc), STICKY ? 32'd2 : 32'd1);
      check_val("pulse_fall_ch",  32'(d0_ch),  32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_val("pulse_clr_blk", 32'(d0_blk), 32'd0);
      check_val("pulse_clr_cyc", 32'(d0_cyc), STICKY ? 32'd2 : 32'd1);

      // ---------------- masked channel 0 never reports
      axis_sigs = 3'b001;
      for (int k = 0; k < 10; k++) begin
         tick();
         check_val($sformatf("mask_blk_%0d", k), 32'(d0_blk), 32'd0);
      end
      axis_sigs = 3'b000;
      tick();

      // ---------------- cause capture and hold, clear priority over raw
      axis_sigs = 3'b100;
      tick();
      check_val("cap_ch2", 32'(d0_ch), 32'd2);
      axis_sigs = 3'b010;
      tick();
      check_val("cap_hold_ch",  32'(d0_ch),  32'd2);
      check_val("cap_hold_cyc", 32'(d0_cyc), 32'd2);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_val("clr_prio_blk", 32'(d0_blk), 32'd0);
      check_val("clr_prio_cyc", 32'(d0_cyc), 32'd2);
      tick();
      check_val("clr_reeval_blk", 32'(d0_blk), 32'd1);
      check_val("clr_reeval_ch",  32'(d0_ch),  32'd1);
      check_val("clr_reeval_cyc", 32'(d0_cyc), 32'd1);

      // ---------------- sub-instance cause
      do_reset();
      inst_blk  = 2'b01;
      inst_idle = 2'b00;
      tick();
      check_val("inst_blk", 32'(d0_blk), 32'd1);
      check_val("inst_ch",  32'(d0_ch),  32'd3);
      do_reset();
      inst_blk  = 2'b01;
      inst_idle = 2'b01;
      tick();
      check_val("inst_idle_blk0", 32'(d0_blk), 32'd0);
      tick();
      check_val("inst_idle_blk1", 32'(d0_blk), 32'd0);
      inst_blk  = 2'b10;
      tick();
      check_val("inst_other_blk", 32'(d0_blk), 32'd1);
      check_val("inst_other_ch",  32'(d0_ch),  32'd3);

      // ---------------- PERSIST = 4: 3 high, 1 low, 4 high
      do_reset();
      axis_sigs = 3'b010;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check_val($sformatf("p4_first_%0d", k), 32'(p4_blk), 32'd0);
      end
      axis_sigs = 3'b000;
      tick();
      check_val("p4_gap", 32'(p4_blk), 32'd0);
      axis_sigs = 3'b010;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_val($sformatf("p4_run_%0d", k), 32'(p4_blk), (k == 4) ? 32'd1 : 32'd0);
      end
      check_val("p4_cyc", 32'(p4_cyc), 32'd1);
      check_val("p4_ch",  32'(p4_ch),  32'd1);

      // ---------------- reset mid-PEND discards progress
      do_reset();
      axis_sigs = 3'b010;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("p4_rst_blk", 32'(p4_blk), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_val($sformatf("p4_rerun_%0d", k), 32'(p4_blk), (k == 4) ? 32'd1 : 32'd0);
      end

      // ---------------- CNT_W = 4 saturation, reset during BLOCKED
      do_reset();
      axis_sigs = 3'b010;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k >= 13) begin
            check_val($sformatf("c4_cyc_%0d", k), 32'(c4_cyc), (k > 15) ? 32'd15 : 32'(k));
         end
      end
      check_val("d0_cyc_20", 32'(d0_cyc), 32'd20);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("c4_rst_blk", 32'(c4_blk), 32'd0);
      check_val("c4_rst_ch",  32'(c4_ch),  32'd0);
      check_val("c4_rst_cyc", 32'(c4_cyc), 32'd0);
      check_val("d0_rst_cyc", 32'(d0_cyc), 32'd0);

      // ---------------- raw high 5 cycles then low, then clear
      do_reset();
      axis_sigs = 3'b010;
      for (int k = 1; k <= 5; k++) begin
         tick();
      end
      check_val("hold_cyc5", 32'(d0_cyc), 32'd5);
      axis_sigs = 3'b000;
      tick();
      check_val("hold_low1_blk", 32'(d0_blk), STICKY ? 32'd1 : 32'd0);
      check_val("hold_low1_cyc", 32'(d0_cyc), STICKY ? 32'd6 : 32'd5);
      tick();
      check_val("hold_low2_blk", 32'(d0_blk), STICKY ? 32'd1 : 32'd0);
      check_val("hold_low2_cyc", 32'(d0_cyc), STICKY ? 32'd7 : 32'd5);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_val("hold_clr_blk", 32'(d0_blk), 32'd0);
      check_val("hold_clr_cyc", 32'(d0_cyc), STICKY ? 32'd7 : 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
